bet_entry: RTL and testbench

Keyboard bet-entry block: converts USB-keyboard keycodes into a binary bet amount for the betting FSM, and is the input-side counterpart of the on-screen money readout. It accumulates up to four decimal digits into an 11-bit value, with backspace, clear and validation against the acting player's stack and minimum bet. It delivers the committed amount over a valid/ack handshake. It also exports the BCD digits it holds so the display can echo the bet in progress without a binary-to-decimal divider.

---
 rtl/bet_entry.sv | 206 ++++++++++++++++++++
 tb/tb_bet_entry.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bet_entry.sv
// bet_entry: keycodes -> 11-bit bet with backspace/escape/stack+min validation; BET_ENTRY_CLAMP_EN clamps over-stack digits to all-in.
// Outputs update at the key's sampling edge. A committed bet is held on bet_valid until bet_ack, and keys are ignored meanwhile.
module bet_entry (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        enable,
  input  logic [7:0]  keycode,
  input  logic [10:0] stack,
  input  logic [10:0] min_bet,
  input  logic        bet_ack,
  output logic [10:0] bet_value,
  output logic [15:0] bet_digits,
  output logic [2:0]  digit_count,
  output logic        bet_valid,
  output logic        bet_error,
  output logic        entry_active
);
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_SUBMIT, S_CONV} state_t;

  localparam logic [7:0] KC_ONE   = 8'h1E;
  localparam logic [7:0] KC_ZERO  = 8'h27;
  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_ESC   = 8'h29;
  localparam logic [7:0] KC_BKSP  = 8'h2A;

  state_t           state_q, state_d;
  logic [10:0]      value_q, value_d;
  logic [15:0]      digits_q, digits_d;
  logic [2:0]       count_q, count_d;
  logic [3:0][10:0] hist_q, hist_d;
  logic [7:0]       prev_key_q, prev_key_d;
  logic             valid_q, valid_d, error_q, error_d, active_q, active_d;
  logic             do_clear;

  logic        key_evt, is_digit;
  logic [3:0]  key_digit;
  logic [14:0] value_ext, cand;

`ifdef BET_ENTRY_CLAMP_EN
  logic [10:0] conv_bin_q, conv_bin_d;
  logic [15:0] conv_bcd_q, conv_bcd_d, conv_adj;
  logic [3:0]  conv_cnt_q, conv_cnt_d;

  function automatic logic [2:0] bcd_len(input logic [15:0] b);
    if (b[15:12] != 4'd0)     return 3'd4;
    else if (b[11:8] != 4'd0) return 3'd3;
    else if (b[7:4] != 4'd0)  return 3'd2;
    else if (b[3:0] != 4'd0)  return 3'd1;
    else                      return 3'd0;
  endfunction
`endif

  assign key_evt   = (keycode != 8'd0) && (keycode != prev_key_q);
  assign is_digit  = (keycode >= KC_ONE) && (keycode <= KC_ZERO);
  assign key_digit = (keycode == KC_ZERO) ? 4'd0 : 4'(keycode - 8'h1D);
  assign value_ext = {4'd0, value_q};
  assign cand      = (value_ext << 3) + (value_ext << 1) + {11'd0, key_digit};

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    digits_d   = digits_q;
    count_d    = count_q;
    hist_d     = hist_q;
    prev_key_d = keycode;
    valid_d    = valid_q;
    error_d    = 1'b0;
    active_d   = active_q;
    do_clear   = 1'b0;
`ifdef BET_ENTRY_CLAMP_EN
    conv_bin_d = conv_bin_q;
    conv_bcd_d = conv_bcd_q;
    conv_cnt_d = conv_cnt_q;
    conv_adj   = conv_bcd_q;
    for (int i = 0; i < 4; i++)
      if (conv_bcd_q[4*i +: 4] >= 4'd5) conv_adj[4*i +: 4] = conv_bcd_q[4*i +: 4] + 4'd3;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_ENTRY;
          active_d = 1'b1;
        end
      end
      S_ENTRY: begin
        if (!enable) begin
          do_clear = 1'b1;
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else if (key_evt) begin
          if (is_digit) begin
            if (count_q < 3'd4 && !(key_digit == 4'd0 && count_q == 3'd0)) begin
              if (cand <= {4'd0, stack}) begin
                value_d  = cand[10:0];
                digits_d = {digits_q[11:0], key_digit};
                count_d  = count_q + 3'd1;
                hist_d   = {hist_q[2:0], value_q};
              end
`ifdef BET_ENTRY_CLAMP_EN
              else begin
                // All-in: digits are rebuilt from stack by the serial converter.
                value_d    = stack;
                hist_d     = {hist_q[2:0], value_q};
                conv_bin_d = stack;
                conv_bcd_d = '0;
                conv_cnt_d = 4'd11;
                state_d    = S_CONV;
              end
`endif
            end
          end else if (keycode == KC_BKSP) begin
            if (count_q != 3'd0) begin
              value_d  = hist_q[0];
              hist_d   = {11'd0, hist_q[3:1]};
              digits_d = {4'd0, digits_q[15:4]};
              count_d  = count_q - 3'd1;
            end
          end else if (keycode == KC_ESC) begin
            do_clear = 1'b1;
          end else if (keycode == KC_ENTER) begin
            if (count_q != 3'd0 && (value_q >= min_bet || value_q == stack)) begin
              state_d  = S_SUBMIT;
              valid_d  = 1'b1;
              active_d = 1'b0;
            end else begin
              error_d = 1'b1;
            end
          end
        end
      end
`ifdef BET_ENTRY_CLAMP_EN
      S_CONV: begin
        if (!enable) begin
          do_clear = 1'b1;
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else begin
          conv_bcd_d = {conv_adj[14:0], conv_bin_q[10]};
          conv_bin_d = {conv_bin_q[9:0], 1'b0};
          conv_cnt_d = conv_cnt_q - 4'd1;
          if (conv_cnt_q == 4'd1) begin
            digits_d = {conv_adj[14:0], conv_bin_q[10]};
            count_d  = bcd_len({conv_adj[14:0], conv_bin_q[10]});
            state_d  = S_ENTRY;
          end
        end
      end
`endif
      S_SUBMIT: begin
        if (bet_ack) begin
          do_clear = 1'b1;
          valid_d  = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_clear) begin
      value_d  = '0;
      digits_d = '0;
      count_d  = '0;
      hist_d   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      value_q    <= '0;
      digits_q   <= '0;
      count_q    <= '0;
      hist_q     <= '0;
      prev_key_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      active_q   <= 1'b0;
`ifdef BET_ENTRY_CLAMP_EN
      conv_bin_q <= '0;
      conv_bcd_q <= '0;
      conv_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      hist_q     <= hist_d;
      prev_key_q <= prev_key_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      active_q   <= active_d;
`ifdef BET_ENTRY_CLAMP_EN
      conv_bin_q <= conv_bin_d;
      conv_bcd_q <= conv_bcd_d;
      conv_cnt_q <= conv_cnt_d;
`endif
    end
  end

  assign bet_value    = value_q;
  assign bet_digits   = digits_q;  // [15:12] is the most significant digit
  assign digit_count  = count_q;
  assign bet_valid    = valid_q;
  assign bet_error    = error_q;
  assign entry_active = active_q;
endmodule

// File: tb/tb_bet_entry.sv
// Bench for bet_entry: per-cycle vector table plus hand-written hold/roll and reset-in-submit sequences.
module tb_bet_entry;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        enable;
  logic [7:0]  keycode;
  logic [10:0] stack;
  logic [10:0] min_bet;
  logic        bet_ack;
  logic [10:0] bet_value;
  logic [15:0] bet_digits;
  logic [2:0]  digit_count;
  logic        bet_valid;
  logic        bet_error;
  logic        entry_active;

  bet_entry dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .keycode(keycode),
    .stack(stack), .min_bet(min_bet), .bet_ack(bet_ack),
    .bet_value(bet_value), .bet_digits(bet_digits), .digit_count(digit_count),
    .bet_valid(bet_valid), .bet_error(bet_error), .entry_active(entry_active)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        en;
    logic [7:0]  kc;
    logic [10:0] stk;
    logic [10:0] mb;
    logic        ack;
    logic [10:0] val;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        vld;
    logic        err;
    logic        act;
  } vec_t;

  vec_t vecs[256];
  int   nv = 0;
  int   cur_s = 500;
  int   cur_m = 20;
  int   checks = 0;
  int   errors = 0;

`ifdef BET_ENTRY_CLAMP_EN
  localparam int V6 = 500;
  localparam int D6 = 'h0500;
`else
  localparam int V6 = 150;
  localparam int D6 = 'h0150;
`endif

  task automatic add(input int en, input int kc, input int ack, input int val, input int dig,
                     input int cnt, input int vld, input int err, input int act);
    vecs[nv].en  = 1'(en);
    vecs[nv].kc  = 8'(kc);
    vecs[nv].stk = 11'(cur_s);
    vecs[nv].mb  = 11'(cur_m);
    vecs[nv].ack = 1'(ack);
    vecs[nv].val = 11'(val);
    vecs[nv].dig = 16'(dig);
    vecs[nv].cnt = 3'(cnt);
    vecs[nv].vld = 1'(vld);
    vecs[nv].err = 1'(err);
    vecs[nv].act = 1'(act);
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input int idx, input int val, input int dig, input int cnt,
                         input int vld, input int err, input int act);
    chk("bet_value", idx, 32'(bet_value), 32'(val));
    chk("bet_digits", idx, 32'(bet_digits), 32'(dig));
    chk("digit_count", idx, 32'(digit_count), 32'(cnt));
    chk("bet_valid", idx, 32'(bet_valid), 32'(vld));
    chk("bet_error", idx, 32'(bet_error), 32'(err));
    chk("entry_active", idx, 32'(entry_active), 32'(act));
  endtask

  task automatic step(input int en, input int kc, input int ack);
    enable  = 1'(en);
    keycode = 8'(kc);
    bet_ack = 1'(ack);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; enable = 1'b1; keycode = 8'h1E; stack = 11'd500; min_bet = 11'd20; bet_ack = 1'b0;

    // Basic bet 150, held until ack; keys in SUBMIT ignored.
    cur_s = 500; cur_m = 20;
    add(1, 'h00, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h1E, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h00, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h22, 0,  15, 'h0015, 2, 0, 0, 1);
    add(1, 'h00, 0,  15, 'h0015, 2, 0, 0, 1);
    add(1, 'h27, 0, 150, 'h0150, 3, 0, 0, 1);
    add(1, 'h00, 0, 150, 'h0150, 3, 0, 0, 1);
    add(1, 'h28, 0, 150, 'h0150, 3, 1, 0, 0);
    add(1, 'h00, 0, 150, 'h0150, 3, 1, 0, 0);
    add(1, 'h1E, 0, 150, 'h0150, 3, 1, 0, 0);
    add(0, 'h00, 1,   0, 'h0000, 0, 0, 0, 0);
    add(0, 'h00, 0,   0, 'h0000, 0, 0, 0, 0);
    add(1, 'h00, 0,   0, 'h0000, 0, 0, 0, 1);
    // Over-stack digit: dropped, or clamped to all-in with serial BCD reload.
    add(1, 'h1E, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h00, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h22, 0,  15, 'h0015, 2, 0, 0, 1);
    add(1, 'h00, 0,  15, 'h0015, 2, 0, 0, 1);
    add(1, 'h27, 0, 150, 'h0150, 3, 0, 0, 1);
    add(1, 'h00, 0, 150, 'h0150, 3, 0, 0, 1);
    add(1, 'h23, 0,  V6, 'h0150, 3, 0, 0, 1);
    for (int k = 0; k < 11; k++)
      add(1, 'h00, 0, V6, (k == 10) ? D6 : 'h0150, 3, 0, 0, 1);
    add(1, 'h29, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h00, 1,   0, 'h0000, 0, 0, 0, 1);
    // Four-digit limit and backspace; ack outside SUBMIT ignored.
    cur_s = 2000;
    add(1, 'h1E, 0,    1, 'h0001, 1, 0, 0, 1);
    add(1, 'h00, 0,    1, 'h0001, 1, 0, 0, 1);
    add(1, 'h1F, 0,   12, 'h0012, 2, 0, 0, 1);
    add(1, 'h00, 0,   12, 'h0012, 2, 0, 0, 1);
    add(1, 'h20, 0,  123, 'h0123, 3, 0, 0, 1);
    add(1, 'h00, 0,  123, 'h0123, 3, 0, 0, 1);
    add(1, 'h21, 0, 1234, 'h1234, 4, 0, 0, 1);
    add(1, 'h00, 1, 1234, 'h1234, 4, 0, 0, 1);
    add(1, 'h22, 0, 1234, 'h1234, 4, 0, 0, 1);
    add(1, 'h00, 0, 1234, 'h1234, 4, 0, 0, 1);
    add(1, 'h2A, 0,  123, 'h0123, 3, 0, 0, 1);
    add(1, 'h00, 0,  123, 'h0123, 3, 0, 0, 1);
    add(1, 'h2A, 0,   12, 'h0012, 2, 0, 0, 1);
    add(1, 'h00, 0,   12, 'h0012, 2, 0, 0, 1);
    add(1, 'h29, 0,    0, 'h0000, 0, 0, 0, 1);
    add(1, 'h00, 0,    0, 'h0000, 0, 0, 0, 1);
    add(1, 'h2A, 0,    0, 'h0000, 0, 0, 0, 1);
    add(1, 'h00, 0,    0, 'h0000, 0, 0, 0, 1);
    add(1, 'h28, 0,    0, 'h0000, 0, 0, 1, 1);
    add(1, 'h00, 0,    0, 'h0000, 0, 0, 0, 1);
    // Below-minimum rejection, then all-in acceptance.
    cur_s = 300; cur_m = 40;
    add(1, 'h20, 0,   3, 'h0003, 1, 0, 0, 1);
    add(1, 'h00, 0,   3, 'h0003, 1, 0, 0, 1);
    add(1, 'h22, 0,  35, 'h0035, 2, 0, 0, 1);
    add(1, 'h00, 0,  35, 'h0035, 2, 0, 0, 1);
    add(1, 'h28, 0,  35, 'h0035, 2, 0, 1, 1);
    add(1, 'h00, 0,  35, 'h0035, 2, 0, 0, 1);
    add(1, 'h29, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h00, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h20, 0,   3, 'h0003, 1, 0, 0, 1);
    add(1, 'h00, 0,   3, 'h0003, 1, 0, 0, 1);
    add(1, 'h27, 0,  30, 'h0030, 2, 0, 0, 1);
    add(1, 'h00, 0,  30, 'h0030, 2, 0, 0, 1);
    add(1, 'h27, 0, 300, 'h0300, 3, 0, 0, 1);
    add(1, 'h00, 0, 300, 'h0300, 3, 0, 0, 1);
    cur_m = 400;
    add(1, 'h28, 0, 300, 'h0300, 3, 1, 0, 0);
    add(1, 'h00, 1,   0, 'h0000, 0, 0, 0, 0);
    add(1, 'h00, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h27, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h00, 0,   0, 'h0000, 0, 0, 0, 1);
    // Enable drop aborts entry; a key in the abort cycle is dropped.
    cur_s = 500; cur_m = 20;
    add(1, 'h1E, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h00, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h1F, 0,  12, 'h0012, 2, 0, 0, 1);
    add(1, 'h00, 0,  12, 'h0012, 2, 0, 0, 1);
    add(0, 'h00, 0,   0, 'h0000, 0, 0, 0, 0);
    add(1, 'h00, 0,   0, 'h0000, 0, 0, 0, 1);
    add(1, 'h1E, 0,   1, 'h0001, 1, 0, 0, 1);
    add(1, 'h00, 0,   1, 'h0001, 1, 0, 0, 1);
    add(0, 'h1F, 0,   0, 'h0000, 0, 0, 0, 0);
    add(0, 'h00, 0,   0, 'h0000, 0, 0, 0, 0);

    // Reset wins over enable and a held key.
    repeat (2) @(posedge Clk);
    #1;
    chk_all(-1, 0, 'h0000, 0, 0, 0, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      stack   = vecs[i].stk;
      min_bet = vecs[i].mb;
      step(32'(vecs[i].en), 32'(vecs[i].kc), 32'(vecs[i].ack));
      chk_all(i, 32'(vecs[i].val), 32'(vecs[i].dig), 32'(vecs[i].cnt),
              32'(vecs[i].vld), 32'(vecs[i].err), 32'(vecs[i].act));
    end

    // Held key gives one event; rolling to another key gives a new one.
    stack = 11'd500; min_bet = 11'd20;
    step(1, 'h00, 0);
    chk("hold_entry_active", 1000, 32'(entry_active), 32'd1);
    for (int c = 0; c < 10; c++) begin
      step(1, 'h1F, 0);
      chk("hold_value", 1001 + c, 32'(bet_value), 32'd2);
    end
    chk("hold_count", 1011, 32'(digit_count), 32'd1);
    step(1, 'h20, 0);
    chk("roll_value", 1012, 32'(bet_value), 32'd23);
    chk("roll_digits", 1013, 32'(bet_digits), 32'h0023);
    step(1, 'h00, 0);
    step(1, 'h28, 0);
    chk("submit_valid", 1014, 32'(bet_valid), 32'd1);
    step(1, 'h00, 0);
    chk("submit_hold", 1015, 32'(bet_value), 32'd23);
    Reset_n = 1'b0;
    step(1, 'h00, 0);
    chk_all(1016, 0, 'h0000, 0, 0, 0, 0);
    Reset_n = 1'b1;
    step(1, 'h00, 0);
    chk("post_reset_active", 1017, 32'(entry_active), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
